// File: rtl/stft_frame_buffer.sv
// stft_frame_buffer: overlapping-window framer for the MEL front end.
// Each sample is stored once; overlap is re-read, flush zero-pads.
module stft_frame_buffer #(
   parameter  int WIDTH      = 32,
   parameter  int CHANNELS   = 1,
   parameter  int WIN_LENGTH = 480,
   parameter  int HOP_LENGTH = 160,
   localparam int DEPTH      = 2**$clog2(WIN_LENGTH+HOP_LENGTH),
   localparam int OCC_W      = $clog2(DEPTH+1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [WIDTH*CHANNELS-1:0] s_data,
   input  logic                      flush,
   output logic                      s_flush_idle,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [WIDTH*CHANNELS-1:0] m_data,
   output logic                      m_first,
   output logic                      m_last,
   output logic                      flush_done,
   output logic [OCC_W-1:0]          occupancy
);

   localparam int DW    = WIDTH*CHANNELS;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int SUM_W = OCC_W+1;
   localparam int CNT_W = $clog2(WIN_LENGTH+1);

   localparam logic [OCC_W-1:0] WIN_O  = OCC_W'(WIN_LENGTH);
   localparam logic [OCC_W-1:0] OVL_O  = OCC_W'(WIN_LENGTH-HOP_LENGTH);
   localparam logic [OCC_W-1:0] DEP_O  = OCC_W'(DEPTH);
   localparam logic [SUM_W-1:0] HOP_S  = SUM_W'(HOP_LENGTH);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(WIN_LENGTH-1);

   typedef enum logic [1:0] {
      FILL,
      EMIT,
      PAD,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   base_q, base_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               emitted_q, emitted_d;
   logic               pend_q, pend_d;
   logic               padded_q, padded_d;
   logic               m_valid_q, m_valid_d;
   logic               m_first_q, m_first_d;
   logic               m_last_q, m_last_d;
   logic [DW-1:0]      m_data_q, m_data_d;
   logic               fdone_q, fdone_d;

   logic [DW-1:0]      mem_q [DEPTH];

   logic               accept;
   logic               pad_wr;
   logic               wr_en;
   logic [PTR_W-1:0]   wr_ptr;
   logic [DW-1:0]      wr_data;
   logic               rd_go;
   logic               issue;
   logic               last_issue;
   logic               fresh;
   logic               done_fire;

   assign s_ready    = (occ_q < DEP_O) && (state_q != PAD);
   assign accept     = s_valid && s_ready;
   assign pad_wr     = (state_q == PAD) && (occ_q != WIN_O);
   assign wr_en      = (accept || pad_wr) && !clr;
   assign wr_data    = pad_wr ? '0 : s_data;
   assign wr_ptr     = PTR_W'(SUM_W'(base_q) + SUM_W'(occ_q));
   assign rd_go      = !m_valid_q || m_ready;
   assign issue      = (state_q == EMIT) && rd_go;
   assign last_issue = issue && (cnt_q == LAST_C);
   // Unemitted samples exist beyond what the next frame will re-read.
   assign fresh      = (occ_q > OVL_O) ||
                       (!emitted_q && (occ_q != '0));

   // Sample store: stream writes and zero padding share one port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= wr_data;
      end
   end

   // Next-state: framing FSM, pointers, occupancy and output beat.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      cnt_d     = cnt_q;
      emitted_d = emitted_q;
      pend_d    = pend_q;
      padded_d  = padded_q;
      m_valid_d = m_valid_q;
      m_first_d = m_first_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      fdone_d   = 1'b0;
      done_fire = 1'b0;

      if (flush && !pend_q) begin
         pend_d = 1'b1;
      end

      if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end

      if (wr_en || last_issue) begin
         occ_d = OCC_W'(SUM_W'(occ_q) + SUM_W'(wr_en)
                        - (last_issue ? HOP_S : '0));
      end

      if (last_issue) begin
         base_d = PTR_W'(SUM_W'(base_q) + HOP_S);
      end

      unique case (state_q)
         FILL: begin
            if (occ_q >= WIN_O) begin
               state_d  = EMIT;
               rd_ptr_d = base_q;
               cnt_d    = '0;
            end else if (pend_q && fresh) begin
               state_d = PAD;
            end else if (pend_q) begin
               state_d = DONE;
            end
         end
         EMIT: begin
            if (issue) begin
               m_data_d  = mem_q[rd_ptr_q];
               m_valid_d = 1'b1;
               m_first_d = (cnt_q == '0);
               m_last_d  = (cnt_q == LAST_C);
               rd_ptr_d  = rd_ptr_q + PTR_W'(1);
               cnt_d     = cnt_q + CNT_W'(1);
               if (last_issue) begin
                  emitted_d = 1'b1;
                  padded_d  = 1'b0;
                  state_d   = (pend_q && padded_q) ? DONE : FILL;
               end
            end
         end
         PAD: begin
            if (occ_q == WIN_O) begin
               state_d  = EMIT;
               padded_d = 1'b1;
               rd_ptr_d = base_q;
               cnt_d    = '0;
            end
         end
         DONE: begin
            if (!m_valid_q || (m_ready && m_last_q)) begin
               done_fire = 1'b1;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase

      // End of flush and clr both return to the post-reset state.
      if (clr || done_fire) begin
         state_d   = FILL;
         base_d    = '0;
         rd_ptr_d  = '0;
         occ_d     = '0;
         cnt_d     = '0;
         emitted_d = 1'b0;
         pend_d    = 1'b0;
         padded_d  = 1'b0;
         m_valid_d = 1'b0;
         m_first_d = 1'b0;
         m_last_d  = 1'b0;
         m_data_d  = '0;
      end

      fdone_d = done_fire && !clr;
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         base_q    <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         cnt_q     <= '0;
         emitted_q <= 1'b0;
         pend_q    <= 1'b0;
         padded_q  <= 1'b0;
         m_valid_q <= 1'b0;
         m_first_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
         fdone_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         cnt_q     <= cnt_d;
         emitted_q <= emitted_d;
         pend_q    <= pend_d;
         padded_q  <= padded_d;
         m_valid_q <= m_valid_d;
         m_first_q <= m_first_d;
         m_last_q  <= m_last_d;
         m_data_q  <= m_data_d;
         fdone_q   <= fdone_d;
      end
   end

   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_first      = m_first_q;
   assign m_last       = m_last_q;
   assign flush_done   = fdone_q;
   assign s_flush_idle = !pend_q;
   assign occupancy    = occ_q;

endmodule
